ahb_dm_bridge: RTL and testbench
================================

Name: ahb_dm_bridge

Overview:
Parametrised CPU data-memory port to AHB master bridge, the successor to the single-transfer data-memory wrapper. It sits between the CPU MEM stage and the AHB arbiter/bus. It adds configurable address/data width, byte/halfword/word sizes, a posted-write buffer, and proper address/data phase sequencing. It also handles RETRY/SPLIT/ERROR responses and returns read data registered and stable until the CPU consumes it.

Parameters:
AW, 32, address width
DW, 32, data width (32 or 64)
WB_DEPTH, 4, posted-write buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
Req  in  1  CPU access request, held until M_ready
Write  in  1  1=store, 0=load
Address  in  AW  CPU byte address
Write_data  in  DW  store data, lane-aligned by CPU
Size  in  3  0=byte, 1=half, 2=word, 3=dword (DW=64 only)
stall  in  1  CPU pipeline stall; a completed read is held while high
Read_data  out  DW  load data
M_ready  out  1  access accepted/completed this cycle
M_err  out  1  one-cycle pulse with M_ready on a read ERROR; sticky-write error see Behaviour
HReq  out  1  bus request to arbiter
HGrant  in  1  grant
HAddress  out  AW  AHB address
HWrite  out  1  AHB write
HTrans  out  `AHB_TRANS_BITS  IDLE=00, NONSEQ=10
HSize  out  `AHB_SIZE_BITS  = Size
HLock  out  1  always 0
HWrite_data  out  DW  AHB write data (data phase)
HRead_data  in  DW  AHB read data
HReady  in  1  transfer ready
HResp  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT

Behaviour:
- Reset: FSM=IDLE, buffer empty, HReq=0, HTrans=IDLE, HAddress=0, HWrite=0, HWrite_data=0, Read_data=0, M_ready=0, M_err=0, wr_err=0.
- FSM states: IDLE, REQ, ADDR, DATA, HOLD.
- IDLE: pending source = buffer head if non-empty, else CPU read if Req&!Write. If a source exists, go to REQ.
- REQ: HReq=1, HTrans=IDLE. Go to ADDR when HGrant&HReady.
- ADDR: drive HAddress/HWrite/HSize, HTrans=NONSEQ, HReq=1. Go to DATA when HReady. The transfer is latched into an internal register.
- DATA: HTrans=IDLE, HReq=0, HWrite_data driven from latched transfer.
  - HReady&OKAY: read → capture HRead_data into Read_data and go to HOLD; write → pop buffer and go to IDLE.
  - HResp=RETRY/SPLIT, first cycle (HReady=0): drop to REQ, reissue the same transfer, no pop.
  - ERROR: read → Read_data=0, M_err set in HOLD; write → pop, set sticky wr_err.
- HOLD: M_ready=1 while the read data is presented. Stay while stall=1. Go to IDLE when stall=0. Read_data is stable throughout.
- Read latency with immediate grant and zero-wait slave: 4 cycles from Req to M_ready.
- Ordering: a CPU read is not issued while the buffer is non-empty. Reads stall until the buffer drains (no forwarding).
- Posted write: Req&Write&!full → enqueue {Address,Write_data,Size}, M_ready=1 the same cycle (combinational).
  - If full, M_ready=0 until a pop.
  - Enqueue and pop in the same cycle is allowed; count is unchanged.
- Buffer pointers are log2(WB_DEPTH) bits and wrap.
- full = (count==WB_DEPTH).
- wr_err: sticky; OR'd into M_err on the next read completion, then cleared.
- rst mid-transfer: immediate return to reset state; buffer contents discarded.
- Misaligned Size/Address combinations are issued as-is, with no checking.

Optional Feature:
DMW_WRITE_POST_EN.
- Defined: posted-write buffer as above.
- Undefined: no buffer (WB_DEPTH ignored).
  - Writes follow the read path through REQ/ADDR/DATA.
  - M_ready is a one-cycle pulse on write completion; HOLD is skipped for writes.
  - A write ERROR pulses M_err with M_ready directly; wr_err is not used.

Test Plan:
- Read addr 0x100, immediate HGrant, HReady=1, HRead_data=0xDEADBEEF → M_ready at cycle 4, Read_data=0xDEADBEEF, HTrans=NONSEQ exactly one cycle.
- Five back-to-back stores, HGrant withheld, WB_DEPTH=4 → M_ready=1 for the first 4; the 5th is held low until the first pop completes.
- Store 0x200 then load 0x200 → load's NONSEQ appears only after the store's data phase completes.
- Read with HResp=RETRY on two cycles, then OKAY with 0x12345678 → same address issued twice, Read_data=0x12345678.
- Read with ERROR → M_ready=1, M_err=1, Read_data=0. Write ERROR (posted) → next read returns M_err=1, and the read after that returns M_err=0.
- Read completes with stall=1 for 3 cycles → M_ready and Read_data held 3 cycles. Assert rst mid-ADDR → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/ahb_dm_bridge.sv
// CPU data-memory port to AHB master bridge: sequences REQ/ADDR/DATA bus phases and holds read data for the CPU.
// Define DMW_WRITE_POST_EN to add the posted-write buffer; otherwise stores complete on the bus like loads.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module ahb_dm_bridge #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Req,
  input  logic                       Write,
  input  logic [AW-1:0]              Address,
  input  logic [DW-1:0]              Write_data,
  input  logic [2:0]                 Size,
  input  logic                       stall,
  output logic [DW-1:0]              Read_data,
  output logic                       M_ready,
  output logic                       M_err,
  output logic                       HReq,
  input  logic                       HGrant,
  output logic [AW-1:0]              HAddress,
  output logic                       HWrite,
  output logic [`AHB_TRANS_BITS-1:0] HTrans,
  output logic [`AHB_SIZE_BITS-1:0]  HSize,
  output logic                       HLock,
  output logic [DW-1:0]              HWrite_data,
  input  logic [DW-1:0]              HRead_data,
  input  logic                       HReady,
  input  logic [1:0]                 HResp
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_HOLD} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    size;
    logic          write;
  } xfer_t;

  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;
  localparam logic [`AHB_TRANS_BITS-1:0] TRANS_IDLE   = '0;
  localparam logic [`AHB_TRANS_BITS-1:0] TRANS_NONSEQ = {1'b1, {(`AHB_TRANS_BITS-1){1'b0}}};

  state_e state_q, state_d;
  xfer_t  cur_q, cur_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          src_valid;
  xfer_t         src;

  assign HLock     = 1'b0;
  assign Read_data = rdata_q;

`ifdef DMW_WRITE_POST_EN
  localparam int unsigned PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

  xfer_t         wb_mem [WB_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          wr_err_q;
  logic          full, enq, pop, wr_err_set, rd_done;

  assign full = (count_q == (PW+1)'(WB_DEPTH));
  assign enq  = Req & Write & ~full;

  // Buffered stores always win over a CPU load so loads observe every earlier store.
  always_comb begin
    src_valid = 1'b0;
    src       = '{addr: Address, data: '0, size: Size, write: 1'b0};
    if (count_q != '0) begin
      src_valid = 1'b1;
      src       = wb_mem[rd_ptr_q];
    end else if (Req && !Write) begin
      src_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (enq && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !enq) count_q <= count_q - 1'b1;
      if (wr_err_set)   wr_err_q <= 1'b1;
      else if (rd_done) wr_err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) wb_mem[wr_ptr_q] <= '{addr: Address, data: Write_data, size: Size, write: 1'b1};
  end
`else
  always_comb begin
    src_valid = Req;
    src       = '{addr: Address, data: Write_data, size: Size, write: Write};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    HReq        = 1'b0;
    HTrans      = TRANS_IDLE;
    HAddress    = '0;
    HWrite      = 1'b0;
    HSize       = '0;
    HWrite_data = '0;
    M_ready     = 1'b0;
    M_err       = 1'b0;
`ifdef DMW_WRITE_POST_EN
    pop         = 1'b0;
    wr_err_set  = 1'b0;
    rd_done     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (src_valid) begin
          cur_d   = src;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        HReq = 1'b1;
        if (HGrant && HReady) state_d = S_ADDR;
      end
      S_ADDR: begin
        HReq     = 1'b1;
        HTrans   = TRANS_NONSEQ;
        HAddress = cur_q.addr;
        HWrite   = cur_q.write;
        HSize    = cur_q.size;
        if (HReady) state_d = S_DATA;
      end
      S_DATA: begin
        HWrite_data = cur_q.data;
        // RETRY/SPLIT is acted on in its first (wait) cycle; cur_q is kept for the reissue.
        if (HResp == RESP_RETRY || HResp == RESP_SPLIT) begin
          state_d = S_REQ;
        end else if (HReady) begin
          if (cur_q.write) begin
            state_d = S_IDLE;
`ifdef DMW_WRITE_POST_EN
            pop        = 1'b1;
            wr_err_set = (HResp == RESP_ERROR);
`else
            M_ready    = 1'b1;
            M_err      = (HResp == RESP_ERROR);
`endif
          end else begin
            rdata_d = (HResp == RESP_ERROR) ? '0 : HRead_data;
`ifdef DMW_WRITE_POST_EN
            err_d   = (HResp == RESP_ERROR) | wr_err_q;
            rd_done = 1'b1;
`else
            err_d   = (HResp == RESP_ERROR);
`endif
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        M_ready = 1'b1;
        M_err   = err_q;
        if (!stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef DMW_WRITE_POST_EN
    M_ready = M_ready | enq;
`endif
  end

endmodule

// File: tb/tb_ahb_dm_bridge.sv
// Self-checking bench for ahb_dm_bridge: randomized AHB slave/arbiter plus a word-memory reference model.
module tb_ahb_dm_bridge;

`ifdef DMW_WRITE_POST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Req, Write, stall;
  logic [31:0] Address, Write_data, Read_data;
  logic [2:0]  Size;
  logic        M_ready, M_err;
  logic        HReq, HGrant, HWrite, HLock, HReady;
  logic [31:0] HAddress, HWrite_data, HRead_data;
  logic [1:0]  HTrans, HResp;
  logic [2:0]  HSize;

  always #5 clk = ~clk;

  ahb_dm_bridge #(.AW(32), .DW(32), .WB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .Req(Req), .Write(Write), .Address(Address),
    .Write_data(Write_data), .Size(Size), .stall(stall), .Read_data(Read_data),
    .M_ready(M_ready), .M_err(M_err), .HReq(HReq), .HGrant(HGrant),
    .HAddress(HAddress), .HWrite(HWrite), .HTrans(HTrans), .HSize(HSize),
    .HLock(HLock), .HWrite_data(HWrite_data), .HRead_data(HRead_data),
    .HReady(HReady), .HResp(HResp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] a, input logic [2:0] s);
    logic [31:0] m;
    case (s)
      3'd0:    m = 32'hFF << (8 * a);
      3'd1:    m = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: m = '1;
    endcase
    return (old & ~m) | (d & m);
  endfunction

  // Reference model: what the CPU should observe; addresses 0xC0-0xFF are an error region.
  logic [31:0] ref_mem [64];
  bit          pend_err = 1'b0;

  // Slave/arbiter state
  logic [31:0] smem [64];
  int          grant_prob = 100, max_wait = 0, retry_prob = 0;
  bit          force_retry = 1'b0;
  bit          dp_active, dp_retry, prev_nonseq, lock_seen = 1'b0;
  int          dp_wait, dp_phase, nonseq_cnt = 0;
  logic [7:0]  dp_addr, prev_addr;
  logic        dp_write, prev_write;
  logic [2:0]  dp_size, prev_size;
  logic [31:0] dp_wdata, last_nonseq_addr;

  always @(negedge clk) begin
    if (rst) begin
      dp_active = 1'b0; prev_nonseq = 1'b0;
      HReady = 1'b1; HResp = 2'b00; HGrant = 1'b0; HRead_data = '0;
    end else begin
      if (dp_active && HReady) begin
        if (HResp == 2'b00 && dp_write)
          smem[dp_addr[7:2]] = merge(smem[dp_addr[7:2]], dp_wdata, dp_addr[1:0], dp_size);
        dp_active = 1'b0;
      end
      if (prev_nonseq && HReady) begin
        dp_active = 1'b1; dp_addr = prev_addr; dp_write = prev_write; dp_size = prev_size;
        dp_wait   = $urandom_range(0, max_wait);
        dp_retry  = force_retry || ($urandom_range(0, 99) < retry_prob);
        force_retry = 1'b0; dp_phase = 0;
      end
      HReady = 1'b1; HResp = 2'b00; HRead_data = '0;
      if (dp_active) begin
        if (dp_wait > 0) begin
          HReady = 1'b0; dp_wait--;
        end else if (dp_retry && dp_phase == 0) begin
          HReady = 1'b0; HResp = 2'b10; dp_phase = 1;
        end else if (dp_retry) begin
          HResp = 2'b10;
        end else begin
          dp_wdata = HWrite_data;
          if (dp_addr >= 8'hC0) begin
            HResp = 2'b01; HRead_data = 32'hBAD0_BAD0;
          end else begin
            HRead_data = smem[dp_addr[7:2]];
          end
        end
      end
      prev_nonseq = (HTrans == 2'b10);
      prev_addr = HAddress[7:0]; prev_write = HWrite; prev_size = HSize;
      if (HTrans == 2'b10) begin
        nonseq_cnt++; last_nonseq_addr = HAddress;
      end
      if (HLock) lock_seen = 1'b1;
      HGrant = ($urandom_range(0, 99) < grant_prob);
    end
  end

  // Called at a falling edge; returns at a falling edge with Req dropped.
  task automatic cpu_access(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                            output logic [31:0] rd, output logic er, output int cyc);
    Req = 1'b1; Write = w; Address = a; Write_data = d; Size = s;
    cyc = 0;
    forever begin
      #1;
      if (M_ready) break;
      if (cyc == 400) begin
        check("ready_timeout", M_ready, 1'b1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    rd = Read_data; er = M_err;
    @(negedge clk);
    Req = 1'b0; Write = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [2:0] s);
    if (a >= 8'hC0) begin
      if (POSTED) pend_err = 1'b1;
    end else begin
      ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, a[1:0], s);
    end
  endtask

  task automatic do_op(input bit w, input logic [7:0] a, input logic [2:0] s, input logic [31:0] d);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    bit          bad;
    bad = (a >= 8'hC0);
    cpu_access(w, {24'h0, a}, d, s, rd, er, cyc);
    if (w) begin
      check("wr_err", er, POSTED ? 1'b0 : bad);
      model_write(a, d, s);
    end else begin
      check("rd_data", rd, bad ? 32'h0 : ref_mem[a[7:2]]);
      check("rd_err", er, bad | pend_err);
      pend_err = 1'b0;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    smem[a[7:2]] = v; ref_mem[a[7:2]] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, d5;
    logic        er;
    int          cyc;
    logic [7:0]  a;
    logic [2:0]  s;

    rst = 1'b1; Req = 1'b0; Write = 1'b0; stall = 1'b0;
    Address = '0; Write_data = '0; Size = '0;
    for (int i = 0; i < 64; i++) begin
      smem[i] = $urandom; ref_mem[i] = smem[i];
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_hreq", HReq, 1'b0);
    check("rst_htrans", HTrans, 2'b00);
    check("rst_haddr", HAddress, 32'h0);
    check("rst_mready", M_ready, 1'b0);
    check("rst_merr", M_err, 1'b0);
    check("rst_rdata", Read_data, 32'h0);
    check("rst_hwdata", HWrite_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait read: four cycles Req to M_ready, one NONSEQ
    preload(8'h00, 32'hDEAD_BEEF);
    nonseq_cnt = 0;
    cpu_access(1'b0, 32'h100, 32'h0, 3'd2, rd, er, cyc);
    check("rd_latency", cyc, 4);
    check("rd_deadbeef", rd, 32'hDEAD_BEEF);
    check("rd_ok_err", er, 1'b0);
    check("rd_nonseq_once", nonseq_cnt, 1);

    // Read held while stalled
    preload(8'h20, 32'hA5A5_5A5A);
    stall = 1'b1;
    cpu_access(1'b0, 32'h20, 32'h0, 3'd2, rd, er, cyc);
    check("stall_first", rd, 32'hA5A5_5A5A);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("stall_hold_ready", M_ready, 1'b1);
      check("stall_hold_data", Read_data, 32'hA5A5_5A5A);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    check("stall_last_ready", M_ready, 1'b1);
    @(negedge clk);
    #1;
    check("stall_released", M_ready, 1'b0);
    @(negedge clk);

    // RETRY reissues the same address
    preload(8'h40, 32'h1234_5678);
    force_retry = 1'b1;
    nonseq_cnt = 0;
    cpu_access(1'b0, 32'h40, 32'h0, 3'd2, rd, er, cyc);
    check("retry_data", rd, 32'h1234_5678);
    check("retry_nonseq_cnt", nonseq_cnt, 2);
    check("retry_addr", last_nonseq_addr, 32'h40);

    // Read ERROR returns zero data with M_err
    do_op(1'b0, 8'hC8, 3'd2, 32'h0);

    // Write ERROR, then two reads
    preload(8'h10, 32'h0BAD_F00D);
    do_op(1'b1, 8'hC4, 3'd2, 32'h5555_AAAA);
    do_op(1'b0, 8'h10, 3'd2, 32'h0);
    do_op(1'b0, 8'h10, 3'd2, 32'h0);

    // Store then load to the same address
    do_op(1'b1, 8'h80, 3'd2, 32'hCAFE_F00D);
    do_op(1'b0, 8'h80, 3'd2, 32'h0);
    do_op(1'b1, 8'h81, 3'd0, 32'h0000_3300);
    do_op(1'b1, 8'h82, 3'd1, 32'h7788_0000);
    do_op(1'b0, 8'h80, 3'd2, 32'h0);

`ifdef DMW_WRITE_POST_EN
    // Five stores with the grant withheld: four fill the buffer, the fifth waits
    grant_prob = 0;
    for (int i = 0; i < 4; i++) begin
      d5 = $urandom;
      cpu_access(1'b1, 32'(i * 4), d5, 3'd2, rd, er, cyc);
      check("post_accept_cycles", cyc, 0);
      model_write(8'(i * 4), d5, 3'd2);
    end
    d5 = $urandom;
    Req = 1'b1; Write = 1'b1; Address = 32'h10; Write_data = d5; Size = 3'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("post_full_hold", M_ready, 1'b0);
      @(negedge clk);
    end
    grant_prob = 100;
    cpu_access(1'b1, 32'h10, d5, 3'd2, rd, er, cyc);
    model_write(8'h10, d5, 3'd2);
    do_op(1'b0, 8'h10, 3'd2, 32'h0);
    do_op(1'b0, 8'h00, 3'd2, 32'h0);
`else
    // Unbuffered store completes with a pulse in its data phase
    d5 = $urandom;
    cpu_access(1'b1, 32'h34, d5, 3'd2, rd, er, cyc);
    check("wr_latency", cyc, 3);
    model_write(8'h34, d5, 3'd2);
    #1;
    check("wr_pulse_end", M_ready, 1'b0);
    @(negedge clk);
    do_op(1'b0, 8'h34, 3'd2, 32'h0);
`endif

    // Randomized traffic: grant delays, wait states, RETRYs, mixed sizes
    grant_prob = 70; max_wait = 2; retry_prob = 15;
    for (int i = 0; i < 200; i++) begin
      s = 3'($urandom_range(0, 2));
      a = 8'($urandom_range(0, 255));
      a = a & ~8'((1 << s) - 1);
      do_op(1'($urandom_range(0, 1)), a, s, $urandom);
    end
    check("hlock_low", lock_seen, 1'b0);

    // Reset while in the address phase
    grant_prob = 100; max_wait = 0; retry_prob = 0;
    Req = 1'b1; Write = 1'b0; Address = 32'h30; Size = 3'd2;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (HTrans == 2'b10) break;
      @(negedge clk);
    end
    check("addr_reached", HTrans, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_hreq", HReq, 1'b0);
    check("midrst_htrans", HTrans, 2'b00);
    check("midrst_haddr", HAddress, 32'h0);
    check("midrst_hwrite", HWrite, 1'b0);
    check("midrst_hwdata", HWrite_data, 32'h0);
    check("midrst_mready", M_ready, 1'b0);
    check("midrst_merr", M_err, 1'b0);
    check("midrst_rdata", Read_data, 32'h0);
    Req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
